commit_unit: RTL and testbench
==============================

# commit_unit

In-order commit stage for the renaming pipeline. It accepts out-of-order completion notifications from the execute pipes and buffers them in a sequence-number-indexed reorder buffer. It then publishes commit notifications strictly in program order, one per cycle. Its commit output is what the decode/issue rename table and free list consume to retire mappings and release previous physical registers.

## Interface

Parameters:
- p_seq_num_bits, 5, width of sequence numbers; ROB depth = 2**p_seq_num_bits entries
- p_phys_addr_bits, 6, physical register index width (36 physical regs)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- complete_val  in  1  completion notification valid
- complete_seq_num  in  p_seq_num_bits  seq num of completing instruction
- complete_waddr  in  5  architectural destination
- complete_preg  in  p_phys_addr_bits  allocated physical destination
- complete_ppreg  in  p_phys_addr_bits  previous physical mapping of waddr
- complete_wen  in  1  instruction writes a register
- commit_val  out  1  commit notification valid
- commit_seq_num  out  p_seq_num_bits  seq num being committed
- commit_waddr  out  5  architectural destination
- commit_preg  out  p_phys_addr_bits  physical destination
- commit_ppreg  out  p_phys_addr_bits  previous physical register, to be freed
- commit_wen  out  1  committed instruction writes a register
- occupancy  out  p_seq_num_bits+1  number of completed, not-yet-committed entries
- err  out  1  sticky protocol-error flag

## Operation

- State:
  - ROB array of 2**p_seq_num_bits entries, each holding {valid, waddr, preg, ppreg, wen}.
  - head pointer, p_seq_num_bits wide.
  - occupancy counter.
  - err flag.
- Completion write: when complete_val is high, entry[complete_seq_num] is written with valid=1 and the payload at the clock edge.
- No handshake: completion is always accepted and commit is never back-pressured.
- Commit:
  - Combinationally, commit_val = entry[head].valid, and the commit_* payload equals entry[head]'s fields, with commit_seq_num = head.
  - When commit_val is high, entry[head].valid clears and head increments at the edge.
  - head wraps modulo 2**p_seq_num_bits: max value -> 0.
- While commit_val is low, commit payload outputs are don't-care; the bench checks them only when commit_val=1.
- occupancy:
  - +1 on completion write only.
  - -1 on commit only.
  - Unchanged when both occur in the same cycle.
  - Never exceeds 2**p_seq_num_bits.
- err:
  - Set when complete_val targets an entry whose valid is already 1 (duplicate or window overrun).
  - On such a completion the entry is overwritten with the new payload, and occupancy does not increment.
  - err stays set until rst.
- Simultaneous completion and commit:
  - A completion to complete_seq_num == head in a cycle where entry[head].valid is 0 is written. It commits in the next cycle, not the same cycle (no bypass).
  - A completion to a different index in the same cycle as a commit proceeds independently.
- Sequence numbers are allocated upstream, in order from 0 after reset. The unit never checks that a completion lies inside the in-flight window beyond the duplicate check.

## Timing

- Completion accepted in cycle N (head matches, no older pending) -> commit_val=1 in cycle N+1.
- Throughput: one commit per cycle. A backlog of k contiguous completed entries drains in k consecutive cycles.
- Reset values:
  - head=0, all entry valid bits=0, occupancy=0, err=0.
  - commit_val=0 in the cycle after rst is sampled high.
- Reset mid-operation:
  - All buffered completions are discarded.
  - complete_val asserted in a rst cycle is ignored.
  - The first post-reset commit is seq_num 0.

## Test plan

- In-order completion: complete seq 0,1,2 in cycles 1,2,3 -> commit_val in cycles 2,3,4 with seq 0,1,2 and matching preg/ppreg/waddr/wen; occupancy ≤1 throughout.
- Out-of-order completion:
  - Complete seq 2 at cycle 1, seq 1 at cycle 2, seq 0 at cycle 3 -> no commit in cycles 2-3, then commits seq 0,1,2 in cycles 4,5,6.
  - occupancy reads 1,2,3,2,1,0.
- Wrap-around (p_seq_num_bits=5): complete and commit seq 0..31, then seq 0 and 1 again -> head wraps 31->0, commits seq 0,1 with new payload, and err stays 0.
- Duplicate completion:
  - Complete seq 3 twice while head=0 -> err=1 after the second completion, occupancy=1, and entry 3 holds the second payload.
  - After completing 0,1,2, commits proceed 0..3.
- Simultaneous events: with entry 0 valid at head, complete seq 1 in the same cycle -> seq 0 commits, occupancy unchanged, seq 1 commits next cycle.
- Reset mid-operation:
  - Complete seq 1,2 (seq 0 pending), assert rst for 1 cycle -> commit_val=0, occupancy=0, err=0.
  - Then complete seq 0 -> commits seq 0 only; stale seq 1,2 never commit.

Source files
------------

// File: rtl/commit_unit.sv
`default_nettype none
// ============================================================================
// Module      : commit_unit
// Description : In-order commit stage. Buffers out-of-order completions in a
//               sequence-number-indexed ROB and retires one per cycle in order.
// Revision    : 1.0 - initial release
// ============================================================================
module commit_unit #(
    parameter int p_seq_num_bits   = 5,
    parameter int p_phys_addr_bits = 6
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic                        complete_val,
    input  logic [p_seq_num_bits-1:0]   complete_seq_num,
    input  logic [4:0]                  complete_waddr,
    input  logic [p_phys_addr_bits-1:0] complete_preg,
    input  logic [p_phys_addr_bits-1:0] complete_ppreg,
    input  logic                        complete_wen,

    output logic                        commit_val,
    output logic [p_seq_num_bits-1:0]   commit_seq_num,
    output logic [4:0]                  commit_waddr,
    output logic [p_phys_addr_bits-1:0] commit_preg,
    output logic [p_phys_addr_bits-1:0] commit_ppreg,
    output logic                        commit_wen,

    output logic [p_seq_num_bits:0]     occupancy,
    output logic                        err
);

    localparam int                        C_DEPTH    = 1 << p_seq_num_bits;
    localparam logic [p_seq_num_bits-1:0] C_HEAD_ONE = 1;
    localparam logic [p_seq_num_bits:0]   C_OCC_ONE  = 1;

    logic [C_DEPTH-1:0]          r_valid;
    logic [4:0]                  r_waddr [C_DEPTH];
    logic [p_phys_addr_bits-1:0] r_preg  [C_DEPTH];
    logic [p_phys_addr_bits-1:0] r_ppreg [C_DEPTH];
    logic                        r_wen   [C_DEPTH];

    logic [p_seq_num_bits-1:0]   r_head;
    logic [p_seq_num_bits:0]     r_occ;
    logic                        r_err;

    logic                        w_commit;
    logic                        w_dup;
    logic                        w_inc;

    // Commit reads only registered state, so a completion to head lands a cycle later.
    assign w_commit = r_valid[r_head];
    assign w_dup    = complete_val && r_valid[complete_seq_num];
    assign w_inc    = complete_val && !r_valid[complete_seq_num];

    assign commit_val     = w_commit;
    assign commit_seq_num = r_head;
    assign commit_waddr   = r_waddr[r_head];
    assign commit_preg    = r_preg[r_head];
    assign commit_ppreg   = r_ppreg[r_head];
    assign commit_wen     = r_wen[r_head];
    assign occupancy      = r_occ;
    assign err            = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_head  <= '0;
            r_occ   <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_commit) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + C_HEAD_ONE;
            end
            // A completion to the committing slot wins and keeps the entry live.
            if (complete_val) begin
                r_valid[complete_seq_num] <= 1'b1;
            end
            if (w_dup) begin
                r_err <= 1'b1;
            end
            case ({w_inc, w_commit})
                2'b10:   r_occ <= r_occ + C_OCC_ONE;
                2'b01:   r_occ <= r_occ - C_OCC_ONE;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Payload storage needs no reset; it is only observed behind a valid bit.
    always_ff @(posedge clk) begin
        if (!rst && complete_val) begin
            r_waddr[complete_seq_num] <= complete_waddr;
            r_preg[complete_seq_num]  <= complete_preg;
            r_ppreg[complete_seq_num] <= complete_ppreg;
            r_wen[complete_seq_num]   <= complete_wen;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_commit_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_commit_unit
// Description : Self-checking bench for commit_unit; expected commits are
//               queued in program order and popped as the DUT retires them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_commit_unit;

    typedef struct packed {
        logic [4:0] seq;
        logic [4:0] waddr;
        logic [5:0] preg;
        logic [5:0] ppreg;
        logic       wen;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       complete_val = 1'b0;
    logic [4:0] complete_seq_num = '0;
    logic [4:0] complete_waddr = '0;
    logic [5:0] complete_preg = '0;
    logic [5:0] complete_ppreg = '0;
    logic       complete_wen = 1'b0;
    logic       commit_val;
    logic [4:0] commit_seq_num;
    logic [4:0] commit_waddr;
    logic [5:0] commit_preg;
    logic [5:0] commit_ppreg;
    logic       commit_wen;
    logic [5:0] occupancy;
    logic       err;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    commit_unit #(.p_seq_num_bits(5), .p_phys_addr_bits(6)) dut (
        .clk              (clk),
        .rst              (rst),
        .complete_val     (complete_val),
        .complete_seq_num (complete_seq_num),
        .complete_waddr   (complete_waddr),
        .complete_preg    (complete_preg),
        .complete_ppreg   (complete_ppreg),
        .complete_wen     (complete_wen),
        .commit_val       (commit_val),
        .commit_seq_num   (commit_seq_num),
        .commit_waddr     (commit_waddr),
        .commit_preg      (commit_preg),
        .commit_ppreg     (commit_ppreg),
        .commit_wen       (commit_wen),
        .occupancy        (occupancy),
        .err              (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input int s, input int salt);
        exp_t e;
        e.seq   = 5'(s % 32);
        e.waddr = 5'((s * 7 + salt) % 32);
        e.preg  = 6'((s * 3 + salt * 5) % 36);
        e.ppreg = 6'((s * 5 + salt + 7) % 36);
        e.wen   = 1'((s + salt) % 2);
        return e;
    endfunction

    // Scoreboard: every retired instruction must match the queue head.
    always @(negedge clk) begin
        if (!rst && commit_val) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL commit_unexpected: got seq=%0d, queue empty", commit_seq_num);
            end else begin
                exp_t e;
                exp_t a;
                e = sb.pop_front();
                a = '{commit_seq_num, commit_waddr, commit_preg, commit_ppreg, commit_wen};
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL commit_payload: got seq=%0d waddr=%0d preg=%0d ppreg=%0d wen=%0d, want seq=%0d waddr=%0d preg=%0d ppreg=%0d wen=%0d",
                             a.seq, a.waddr, a.preg, a.ppreg, a.wen, e.seq, e.waddr, e.preg, e.ppreg, e.wen);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input exp_t e);
        complete_val     = 1'b1;
        complete_seq_num = e.seq;
        complete_waddr   = e.waddr;
        complete_preg    = e.preg;
        complete_ppreg   = e.ppreg;
        complete_wen     = e.wen;
    endtask

    task automatic idle();
        complete_val = 1'b0;
    endtask

    task automatic expect_state(input string name, input logic cv, input logic [4:0] seq,
                                input logic [5:0] occ);
        n_checks++;
        if (commit_val !== cv || occupancy !== occ || (cv && commit_seq_num !== seq)) begin
            n_fail++;
            $display("FAIL %s: got commit_val=%0b seq=%0d occ=%0d, want commit_val=%0b seq=%0d occ=%0d",
                     name, commit_val, commit_seq_num, occupancy, cv, seq, occ);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        idle();
        while (sb.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        tick();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d commits outstanding, want 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        tick();
        n_checks++;
        if (commit_val !== 1'b0 || occupancy !== 6'd0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: got commit_val=%0b occ=%0d err=%0b, want 0 0 0",
                     commit_val, occupancy, err);
        end
        sb.delete();
        rst = 1'b0;
    endtask

    task automatic test_in_order();
        test_reset();
        for (int i = 0; i < 3; i++) sb.push_back(mk(i, 0));
        for (int i = 0; i < 3; i++) begin
            drive(mk(i, 0));
            tick();
            expect_state("in_order", 1'b1, 5'(i), 6'd1);
        end
        idle();
        tick();
        expect_state("in_order_idle", 1'b0, 5'd0, 6'd0);
        drain("in_order");
    endtask

    task automatic test_out_of_order();
        logic [5:0] occ_exp [6] = '{6'd1, 6'd2, 6'd3, 6'd2, 6'd1, 6'd0};
        test_reset();
        for (int i = 0; i < 3; i++) sb.push_back(mk(i, 9));
        for (int c = 0; c < 6; c++) begin
            if (c < 3) drive(mk(2 - c, 9));
            else idle();
            tick();
            expect_state("out_of_order", (c >= 2 && c <= 4), 5'(c - 2), occ_exp[c]);
        end
        drain("out_of_order");
    endtask

    task automatic test_wrap();
        test_reset();
        for (int i = 0; i < 34; i++) begin
            sb.push_back(mk(i % 32, (i < 32) ? 1 : 2));
            drive(mk(i % 32, (i < 32) ? 1 : 2));
            tick();
            expect_state("wrap", 1'b1, 5'(i % 32), 6'd1);
        end
        drain("wrap");
        n_checks++;
        if (err !== 1'b0 || occupancy !== 6'd0) begin
            n_fail++;
            $display("FAIL wrap_err: got err=%0b occ=%0d, want err=0 occ=0", err, occupancy);
        end
    endtask

    task automatic test_duplicate();
        test_reset();
        for (int i = 0; i < 3; i++) sb.push_back(mk(i, 3));
        sb.push_back(mk(3, 5));
        drive(mk(3, 4));
        tick();
        n_checks++;
        if (err !== 1'b0 || occupancy !== 6'd1) begin
            n_fail++;
            $display("FAIL dup_first: got err=%0b occ=%0d, want err=0 occ=1", err, occupancy);
        end
        drive(mk(3, 5));
        tick();
        n_checks++;
        if (err !== 1'b1 || occupancy !== 6'd1 || commit_val !== 1'b0) begin
            n_fail++;
            $display("FAIL dup_second: got err=%0b occ=%0d commit_val=%0b, want err=1 occ=1 commit_val=0",
                     err, occupancy, commit_val);
        end
        for (int i = 0; i < 3; i++) begin
            drive(mk(i, 3));
            tick();
        end
        drain("duplicate");
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL dup_sticky: got err=%0b, want 1", err);
        end
    endtask

    task automatic test_simultaneous();
        test_reset();
        sb.push_back(mk(0, 6));
        sb.push_back(mk(1, 6));
        sb.push_back(mk(2, 6));
        drive(mk(0, 6));
        tick();
        expect_state("simul_head", 1'b1, 5'd0, 6'd1);
        drive(mk(1, 6));
        tick();
        expect_state("simul_both", 1'b1, 5'd1, 6'd1);
        idle();
        tick();
        expect_state("simul_empty", 1'b0, 5'd0, 6'd0);
        drive(mk(2, 6));
        #1;
        n_checks++;
        if (commit_val !== 1'b0) begin
            n_fail++;
            $display("FAIL no_bypass: got commit_val=%0b, want 0", commit_val);
        end
        tick();
        expect_state("simul_next", 1'b1, 5'd2, 6'd1);
        drain("simultaneous");
    endtask

    task automatic test_reset_mid();
        test_reset();
        drive(mk(1, 8));
        tick();
        drive(mk(2, 8));
        tick();
        expect_state("mid_pending", 1'b0, 5'd0, 6'd2);
        rst = 1'b1;
        drive(mk(0, 11));
        tick();
        n_checks++;
        if (commit_val !== 1'b0 || occupancy !== 6'd0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got commit_val=%0b occ=%0d err=%0b, want 0 0 0",
                     commit_val, occupancy, err);
        end
        rst = 1'b0;
        idle();
        tick();
        expect_state("mid_ignored", 1'b0, 5'd0, 6'd0);
        sb.push_back(mk(0, 8));
        drive(mk(0, 8));
        tick();
        expect_state("mid_first", 1'b1, 5'd0, 6'd1);
        idle();
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_state("mid_stale", 1'b0, 5'd0, 6'd0);
        end
        drain("reset_mid");
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_out_of_order();
        test_wrap();
        test_duplicate();
        test_simultaneous();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
